// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART receiver.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  // Bit-period divisor rounded to the nearest clock cycle.
  function automatic int unsigned uart_div(input int unsigned clk_freq, input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only if a pop frees a slot that cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     arstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_depth_check
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign drop_c   = push & full & ~do_pop;
  // Gate the head so a reset or drained buffer never exposes stale storage.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with mid-bit sampling, feeding a show-ahead byte FIFO.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          arstn,
  input  logic                          serial_in,
  output logic [UART_DATA_BITS-1:0]     data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          frame_err_o,
  output logic                          overflow_o
);

  localparam int unsigned DIV   = uart_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);

  if (DIV < 4) begin : g_div_check
    $error("uart_rx_buffered: CLK_FREQ/BAUD_RATE must be at least 4");
  end

  logic [1:0]                sync_q;
  logic                      rx;
  logic                      rx_prev;
  rx_state_t                 state;
  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      byte_push;
  logic                      fifo_full;
  logic                      fifo_empty;

  assign rx = sync_q[1];

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      sync_q  <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], serial_in};
      rx_prev <= rx;
    end
  end

  // Deframer: count from the detected edge to mid-bit, then step one bit period per sample.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      byte_push   <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      byte_push   <= 1'b0;
      frame_err_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx && rx_prev) begin
            state   <= START;
            cnt     <= '0;
            bit_idx <= '0;
          end
        end
        START: begin
          if (cnt == CNT_W'(HALF - 1)) begin
            cnt   <= '0;
            state <= rx ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_W'(DIV - 1)) begin
            cnt     <= '0;
            shreg   <= {rx, shreg[UART_DATA_BITS-1:1]};
            bit_idx <= bit_idx + IDX_W'(1);
            if (bit_idx == IDX_W'(UART_DATA_BITS - 1)) state <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == CNT_W'(DIV - 1)) begin
            cnt         <= '0;
            state       <= IDLE;
            byte_push   <= rx;
            frame_err_o <= ~rx;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .arstn     (arstn),
    .push      (byte_push),
    .push_data (shreg),
    .pop       (ready_i),
    .pop_data  (data_o),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level_o),
    .drop_c    (overflow_o)
  );

  assign valid_o = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered at DIV=16, HALF=8, FIFO_DEPTH=4.
`timescale 1ns/1ps
module tb_uart_rx_buffered;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned LW       = 3;
  localparam int          BITLEN   = 16;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         lvl;
    int         head;
    int         fe;
    int         ov;
  } vec_t;

  logic          clk = 1'b0;
  logic          arstn;
  logic          serial_in;
  logic          ready_i;
  logic [7:0]    data_o;
  logic          valid_o;
  logic [LW-1:0] level_o;
  logic          frame_err_o;
  logic          overflow_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   rise_cyc = 0;
  int   fe_cyc  = 0;
  int   fe_cnt  = 0;
  int   ov_cnt  = 0;
  logic valid_q = 1'b0;

  uart_rx_buffered #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .arstn       (arstn),
    .serial_in   (serial_in),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .level_o     (level_o),
    .frame_err_o (frame_err_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled a little after the falling edge once inputs have settled.
  always @(negedge clk) begin
    #2;
    if (valid_o && !valid_q) rise_cyc = cyc;
    valid_q = valid_o;
    if (frame_err_o) begin
      fe_cnt = fe_cnt + 1;
      fe_cyc = cyc;
    end
    if (overflow_o) ov_cnt = ov_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests = n_tests + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one 8N1 frame; must be called at a falling clock edge.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      serial_in = bits[i];
      repeat (BITLEN) @(negedge clk);
    end
  endtask

  task automatic pop_check(input string name, input int exp, input int lvl_after);
    check({name, "_valid"}, int'(valid_o), 1);
    check({name, "_data"}, int'(data_o), exp);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    check({name, "_level"}, int'(level_o), lvl_after);
  endtask

  initial begin
    vec_t vecs[7];
    int   v0;
    int   fe0;
    int   ov0;

    vecs[0] = '{8'h55, 1'b0, 0, 8'h00, 1, 0};
    vecs[1] = '{8'h12, 1'b1, 1, 8'h12, 0, 0};
    vecs[2] = '{8'h34, 1'b1, 2, 8'h12, 0, 0};
    vecs[3] = '{8'h56, 1'b1, 3, 8'h12, 0, 0};
    vecs[4] = '{8'h78, 1'b1, 4, 8'h12, 0, 0};
    vecs[5] = '{8'h77, 1'b1, 4, 8'h12, 0, 1};
    vecs[6] = '{8'h99, 1'b0, 4, 8'h12, 1, 0};

    arstn     = 1'b0;
    serial_in = 1'b1;
    ready_i   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", int'(valid_o), 0);
    check("rst_data", int'(data_o), 0);
    check("rst_level", int'(level_o), 0);
    check("rst_ferr", int'(frame_err_o), 0);
    check("rst_ovf", int'(overflow_o), 0);
    arstn = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte: valid rises two cycles after the stop sample.
    v0 = cyc;
    send_frame(8'hA5, 1'b1);
    check("a5_rise_cycle", rise_cyc - v0, 156);
    check("a5_data", int'(data_o), 8'hA5);
    check("a5_level", int'(level_o), 1);
    check("a5_ferr_cnt", fe_cnt, 0);
    check("a5_ovf_cnt", ov_cnt, 0);
    pop_check("a5_pop", 8'hA5, 0);

    // Back-to-back frames with no idle time between stop and next start.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    check("b2b_level", int'(level_o), 3);
    pop_check("b2b_pop0", 8'h00, 2);
    pop_check("b2b_pop1", 8'hFF, 1);
    pop_check("b2b_pop2", 8'h3C, 0);
    check("b2b_valid_empty", int'(valid_o), 0);

    // Short glitch is a false start; a frame right behind it must still be caught.
    fe0 = fe_cnt;
    serial_in = 1'b0;
    repeat (4) @(negedge clk);
    serial_in = 1'b1;
    repeat (8) @(negedge clk);
    send_frame(8'hC3, 1'b1);
    repeat (8) @(negedge clk);
    check("glitch_level", int'(level_o), 1);
    check("glitch_data", int'(data_o), 8'hC3);
    check("glitch_ferr", fe_cnt - fe0, 0);
    pop_check("glitch_pop", 8'hC3, 0);

    // Frame error pulse lands one cycle after the stop sample.
    fe0 = fe_cnt;
    v0  = cyc;
    send_frame(8'h5A, 1'b0);
    serial_in = 1'b1;
    repeat (8) @(negedge clk);
    check("ferr_cycle", fe_cyc - v0, 155);
    check("ferr_count", fe_cnt - fe0, 1);

    // Break: line held low yields exactly one frame error.
    fe0 = fe_cnt;
    serial_in = 1'b0;
    repeat (400) @(negedge clk);
    serial_in = 1'b1;
    repeat (20) @(negedge clk);
    check("break_ferr", fe_cnt - fe0, 1);
    check("break_level", int'(level_o), 0);

    for (int i = 0; i < 7; i++) begin
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      send_frame(vecs[i].data, vecs[i].stop);
      serial_in = 1'b1;
      repeat (8) @(negedge clk);
      check($sformatf("vec%0d_level", i), int'(level_o), vecs[i].lvl);
      check($sformatf("vec%0d_valid", i), int'(valid_o), (vecs[i].lvl != 0) ? 1 : 0);
      check($sformatf("vec%0d_data", i), int'(data_o), vecs[i].head);
      check($sformatf("vec%0d_ferr", i), fe_cnt - fe0, vecs[i].fe);
      check($sformatf("vec%0d_ovf", i), ov_cnt - ov0, vecs[i].ov);
    end

    // Push into a full FIFO while the consumer pops in that same cycle.
    ov0 = ov_cnt;
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (155) @(negedge clk);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
      end
    join
    check("fullpop_level", int'(level_o), 4);
    check("fullpop_ovf", ov_cnt - ov0, 0);
    pop_check("drain0", 8'h34, 3);
    pop_check("drain1", 8'h56, 2);
    pop_check("drain2", 8'h78, 1);
    pop_check("drain3", 8'h77, 0);

    // Reset in the middle of data bit 4 with two bytes queued.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check("prerst_level", int'(level_o), 2);
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (88) @(negedge clk);
        arstn = 1'b0;
        #1;
        check("midrst_valid", int'(valid_o), 0);
        check("midrst_data", int'(data_o), 0);
        check("midrst_level", int'(level_o), 0);
        check("midrst_ferr", int'(frame_err_o), 0);
        check("midrst_ovf", int'(overflow_o), 0);
        @(negedge clk);
        @(negedge clk);
        arstn = 1'b1;
      end
    join
    serial_in = 1'b1;
    repeat (20) @(negedge clk);
    check("postrst_level_idle", int'(level_o), 0);
    send_frame(8'h81, 1'b1);
    repeat (4) @(negedge clk);
    check("postrst_level", int'(level_o), 1);
    check("postrst_data", int'(data_o), 8'h81);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
